// File: rtl/nordstrom_checkout.sv
// nordstrom_checkout: checkout-lane controller classifying UPC scans with saturating totals and stolen-item alarm lock
module nordstrom_checkout #(
    parameter int UPC_W = 4,
    parameter int CNT_W = 8,
    parameter logic [2**UPC_W-1:0] DISC_MASK   = 16'h6868,
    parameter logic [2**UPC_W-1:0] STOLEN_MASK = 16'h0023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_valid,
    output logic             scan_ready,
    input  logic [UPC_W-1:0] scan_upc,
    input  logic             checkout,
    input  logic             clear,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] disc_count,
    output logic             disc_flag,
    output logic             stolen_flag,
    output logic             alarm,
    output logic             total_valid
);
    typedef enum logic [1:0] {IDLE, OPEN, ALARM, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] item_nx, disc_nx, item_base, disc_base;
    logic dflag_nx, sflag_nx, acc, stolen, disc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign acc         = scan_valid && scan_ready;
    assign stolen      = STOLEN_MASK[scan_upc];
    assign disc        = DISC_MASK[scan_upc] && !stolen;
    assign alarm       = state == ALARM;
    assign total_valid = state == DONE;
    // a scan outside OPEN starts a fresh transaction
    assign item_base   = (state == OPEN) ? item_count : '0;
    assign disc_base   = (state == OPEN) ? disc_count : '0;

    always_comb begin
        state_nx = state;
        item_nx  = item_count;
        disc_nx  = disc_count;
        dflag_nx = disc_flag;
        sflag_nx = stolen_flag;
        if (clear) begin
            dflag_nx = 1'b0;
            sflag_nx = 1'b0;
            state_nx = (state == ALARM) ? OPEN : IDLE;
            item_nx  = (state == ALARM) ? item_count : '0;
            disc_nx  = (state == ALARM) ? disc_count : '0;
        end else if (acc) begin
            dflag_nx = disc;
            sflag_nx = stolen;
            item_nx  = stolen ? item_base : sat_inc(item_base);
            disc_nx  = disc ? sat_inc(disc_base) : disc_base;
            state_nx = stolen ? ALARM : (state == OPEN && checkout) ? DONE : OPEN;
        end else if (checkout && state == OPEN) begin
            state_nx = DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            item_count  <= '0;
            disc_count  <= '0;
            disc_flag   <= 1'b0;
            stolen_flag <= 1'b0;
            scan_ready  <= 1'b0;
        end else begin
            state       <= state_nx;
            item_count  <= item_nx;
            disc_count  <= disc_nx;
            disc_flag   <= dflag_nx;
            stolen_flag <= sflag_nx;
            scan_ready  <= state_nx != ALARM;
        end
    end
endmodule

// File: tb/tb_nordstrom_checkout.sv
// tb_nordstrom_checkout: directed and randomized checks of nordstrom_checkout against a behavioural lane model
module tb_nordstrom_checkout;
    logic clk = 1'b0, reset_n = 1'b0, scan_valid = 1'b0, checkout = 1'b0, clear = 1'b0;
    logic [3:0] scan_upc = '0;
    logic scan_ready, disc_flag, stolen_flag, alarm, total_valid;
    logic scan_ready2, disc_flag2, stolen_flag2, alarm2, total_valid2;
    logic [7:0] item_count, disc_count;
    logic [1:0] item_count2, disc_count2;
    localparam logic [15:0] DM = 16'h6868;
    localparam logic [15:0] SM = 16'h0023;

    always #5 clk = ~clk;

    nordstrom_checkout dut (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_upc(scan_upc), .checkout(checkout), .clear(clear), .item_count(item_count),
        .disc_count(disc_count), .disc_flag(disc_flag), .stolen_flag(stolen_flag),
        .alarm(alarm), .total_valid(total_valid));

    nordstrom_checkout #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(scan_ready2),
        .scan_upc(scan_upc), .checkout(checkout), .clear(clear), .item_count(item_count2),
        .disc_count(disc_count2), .disc_flag(disc_flag2), .stolen_flag(stolen_flag2),
        .alarm(alarm2), .total_valid(total_valid2));

    int n_vec = 0, n_bad = 0;
    int m_items, m_discs;
    bit m_ready, m_open, m_locked, m_closed, m_df, m_sf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {m_ready, m_open, m_locked, m_closed, m_df, m_sf} = '0;
        m_items = 0;
        m_discs = 0;
    endtask

    task automatic model_step(input bit sv, input int upc, input bit co, input bit clr);
        bit acc, st, ds;
        acc = sv && m_ready;
        st = SM[upc];
        ds = DM[upc] && !st;
        if (clr) begin
            m_df = 0;
            m_sf = 0;
            if (m_locked) begin
                m_locked = 0;
                m_open = 1;
            end else begin
                m_open = 0;
                m_closed = 0;
                m_items = 0;
                m_discs = 0;
            end
        end else if (acc) begin
            m_df = ds;
            m_sf = st;
            if (!m_open) begin
                m_items = 0;
                m_discs = 0;
            end
            if (st) begin
                m_locked = 1;
                m_open = 0;
                m_closed = 0;
            end else begin
                m_items++;
                if (ds) m_discs++;
                m_closed = m_open && co;
                m_open = !m_closed;
            end
        end else if (co && m_open) begin
            m_open = 0;
            m_closed = 1;
        end
        m_ready = !m_locked;
    endtask

    task automatic compare_all();
        check("scan_ready", scan_ready, m_ready);
        check("item_count", item_count, (m_items > 255) ? 255 : m_items);
        check("disc_count", disc_count, (m_discs > 255) ? 255 : m_discs);
        check("item_count_w2", item_count2, (m_items > 3) ? 3 : m_items);
        check("disc_count_w2", disc_count2, (m_discs > 3) ? 3 : m_discs);
        check("disc_flag", disc_flag, m_df);
        check("stolen_flag", stolen_flag, m_sf);
        check("alarm", alarm, m_locked);
        check("total_valid", total_valid, m_closed);
    endtask

    task automatic cyc(input bit sv, input int upc, input bit co, input bit clr);
        scan_valid = sv;
        scan_upc = 4'(upc);
        checkout = co;
        clear = clr;
        @(posedge clk);
        model_step(sv, upc, co, clr);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        cyc(0, 0, 0, 0);
        check("ready_after_reset", scan_ready, 1);
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        cyc(1, 6, 0, 0);
        cyc(0, 0, 1, 0);
        check("tp1_items", item_count, 3);
        check("tp1_discs", disc_count, 2);
        check("tp1_dflag", disc_flag, 1);
        check("tp1_total", total_valid, 1);
        cyc(1, 7, 0, 1);
        check("done_clear_items", item_count, 0);
        check("done_clear_total", total_valid, 0);
        cyc(1, 4, 0, 0);
        cyc(1, 5, 0, 0);
        check("stolen_alarm", alarm, 1);
        check("stolen_ready", scan_ready, 0);
        check("stolen_items", item_count, 1);
        cyc(1, 4, 0, 0);
        check("alarm_frozen", item_count, 1);
        cyc(0, 0, 0, 1);
        check("ack_alarm", alarm, 0);
        check("ack_ready", scan_ready, 1);
        check("ack_items", item_count, 1);
        cyc(1, 4, 0, 0);
        cyc(1, 4, 1, 0);
        check("scan_co_items", item_count, 3);
        check("scan_co_total", total_valid, 1);
        cyc(1, 11, 0, 0);
        check("restart_items", item_count, 1);
        check("restart_discs", disc_count, 1);
        check("restart_total", total_valid, 0);
        cyc(1, 1, 1, 0);
        check("stolen_co_alarm", alarm, 1);
        check("stolen_co_total", total_valid, 0);
        cyc(0, 0, 0, 1);
        repeat (5) cyc(1, 3, 0, 0);
        check("sat_items_w2", item_count2, 3);
        check("sat_discs_w2", disc_count2, 3);
        check("wide_items", item_count, 6);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                reset_n = 1'b1;
            end
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 15),
                $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        check("pre_reset_alarm", alarm, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_reset_alarm", alarm, 0);
        check("async_reset_ready", scan_ready, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
